data_mem_uart: RTL



---
 rtl/data_mem_uart_if.sv | 10 +
 rtl/data_mem_uart.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/data_mem_uart_if.sv
// CPU load/store port between the memory stage (master) and the data-side subsystem (slave).
interface data_mem_uart_if;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wr_data_i;
  logic        mem_wr_sig_i;
  logic [31:0] mem_rd_data_o;

  modport master (output mem_addr_i, mem_wr_data_i, mem_wr_sig_i, input mem_rd_data_o);
  modport slave  (input mem_addr_i, mem_wr_data_i, mem_wr_sig_i, output mem_rd_data_o);
endinterface

// File: rtl/data_mem_uart.sv
// Data RAM, 8N1 UART transmitter behind a byte FIFO, and a free-running cycle counter.
//
// state | meaning
// IDLE  | line high; pops FIFO head into the shift register when one is waiting
// START | start bit, line low for CLKS_PER_BIT cycles
// DATA  | 8 data bits LSB first, each held CLKS_PER_BIT cycles
// STOP  | stop bit, line high for CLKS_PER_BIT cycles
module data_mem_uart #(
  parameter int          RAM_WORDS    = 1024,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] CYCLES_RESET = 32'h0
) (
  input  logic           clk,
  input  logic           reset_n,
  data_mem_uart_if.slave bus,
  output logic           uart_tx_o
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TXDATA_A = 32'h1000_0000;
  localparam logic [31:0] STATUS_A = 32'h1000_0004;
  localparam logic [31:0] CYCLES_A = 32'h1000_0008;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t      state_q, state_d;
  logic [31:0]    word_addr;
  logic           in_ram;
  logic [RAW-1:0] ram_idx;
  logic           addr_lsb_unused;
  logic [31:0]    ram [RAM_WORDS];
  logic [7:0]     fifo [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    count_q;
  logic           fifo_full, fifo_empty, push, pop;
  logic [BW-1:0]  baud_q;
  logic           baud_done;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;
  logic           tx_busy;
  logic [31:0]    cycles_q;
  logic [31:0]    status;

  assign word_addr       = {bus.mem_addr_i[31:2], 2'b00};
  assign in_ram          = (bus.mem_addr_i[31:RAW+2] == '0);
  assign ram_idx         = bus.mem_addr_i[RAW+1:2];
  assign addr_lsb_unused = ^bus.mem_addr_i[1:0];

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  // A push into a full FIFO is dropped even when the same edge pops.
  assign push = bus.mem_wr_sig_i && (word_addr == TXDATA_A) && !fifo_full;
  assign pop  = (state_q == IDLE) && !fifo_empty;
  assign baud_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (bus.mem_wr_sig_i && in_ram) ram[ram_idx] <= bus.mem_wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr_q] <= bus.mem_wr_data_i[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (baud_done) state_d = DATA;
      DATA:    if (baud_done && bit_idx_q == 3'd7) state_d = STOP;
      STOP:    if (baud_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_tx_o = 1'b1;
    tx_busy   = 1'b1;
    case (state_q)
      IDLE:    tx_busy   = 1'b0;
      START:   uart_tx_o = 1'b0;
      DATA:    uart_tx_o = shift_q[bit_idx_q];
      default: ;
    endcase
  end

  // Baud counter restarts on every state change and on every data bit boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      if (state_q != state_d || (state_q == DATA && baud_done)) baud_q <= '0;
      else if (state_q != IDLE)                                 baud_q <= baud_q + 1'b1;
      if (state_q == START)                  bit_idx_q <= '0;
      else if (state_q == DATA && baud_done) bit_idx_q <= bit_idx_q + 1'b1;
      if (pop) shift_q <= fifo[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycles_q <= CYCLES_RESET;
    else          cycles_q <= cycles_q + 32'd1;
  end

  assign status = {16'h0, 8'(count_q), 5'h0, tx_busy, fifo_empty, fifo_full};

  always_comb begin
    bus.mem_rd_data_o = '0;
    if (in_ram) begin
      bus.mem_rd_data_o = ram[ram_idx];
    end else begin
      case (word_addr)
        STATUS_A: bus.mem_rd_data_o = status;
        CYCLES_A: bus.mem_rd_data_o = cycles_q;
        default:  bus.mem_rd_data_o = '0;
      endcase
    end
  end

endmodule
